// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with a latency-matched pixel pipeline.
// Ports: in  pclk, reset (sync, active-high), pix_ce, vga_data[3*CW], pattern_sel (VGA_TEST_PATTERN_EN only)
//        out h_addr/v_addr[AW], addr_req, hsync, vsync, valid, frame_start, line_start, vga_r/g/b[CW]
// Optional feature macro: VGA_TEST_PATTERN_EN (adds pattern_sel and an 8-bar colour generator).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int DATA_LAT = 1,
    parameter int CW       = 8,
    parameter int AW       = 10
) (
    input  logic            pclk,
    input  logic            reset,
    input  logic            pix_ce,
    input  logic [3*CW-1:0] vga_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic            pattern_sel,
`endif
    output logic [AW-1:0]   h_addr,
    output logic [AW-1:0]   v_addr,
    output logic            addr_req,
    output logic            hsync,
    output logic            vsync,
    output logic            valid,
    output logic            frame_start,
    output logic            line_start,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int D       = DATA_LAT + 1;

    localparam logic [AW-1:0] H_ACT = AW'(H_ACTIVE);
    localparam logic [AW-1:0] H_SS  = AW'(H_ACTIVE + H_FP);
    localparam logic [AW-1:0] H_SE  = AW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [AW-1:0] H_MAX = AW'(H_TOTAL - 1);
    localparam logic [AW-1:0] V_ACT = AW'(V_ACTIVE);
    localparam logic [AW-1:0] V_SS  = AW'(V_ACTIVE + V_FP);
    localparam logic [AW-1:0] V_SE  = AW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW-1:0] V_MAX = AW'(V_TOTAL - 1);

    // Control bundle bit positions inside the display delay line
    localparam int C_HS = 0;
    localparam int C_VS = 1;
    localparam int C_VD = 2;
    localparam int C_LS = 3;
    localparam int C_FS = 4;

    logic [AW-1:0] h_cnt;
    logic [AW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt == H_MAX);
    assign v_last = (v_cnt == V_MAX);

    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Fetch stage: address presented to the upstream frame source
    assign addr_req = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign h_addr   = addr_req ? h_cnt : '0;
    assign v_addr   = addr_req ? v_cnt : '0;

    logic       hs_src;
    logic       vs_src;
    logic       fs_src;
    logic       ls_src;
    logic [4:0] ctl_src;

    assign hs_src  = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign vs_src  = (v_cnt >= V_SS) && (v_cnt < V_SE);
    assign fs_src  = (h_cnt == '0) && (v_cnt == '0);
    assign ls_src  = (h_cnt == '0) && (v_cnt < V_ACT);
    assign ctl_src = {fs_src, ls_src, addr_req, vs_src, hs_src};

    // Sync levels are carried active-high and converted to pin polarity at the end,
    // so a cleared delay line naturally means "sync inactive".
    logic [4:0] ctl_d [D];

    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) ctl_d[i] <= '0;
        end else if (pix_ce) begin
            ctl_d[0] <= ctl_src;
            for (int i = 1; i < D; i++) ctl_d[i] <= ctl_d[i-1];
        end
    end

    // addr_req delayed by DATA_LAT: lines up with the vga_data for the same pixel
    logic req_tap;

    generate
        if (DATA_LAT == 0) begin : g_tap0
            assign req_tap = addr_req;
        end else begin : g_tapn
            assign req_tap = ctl_d[DATA_LAT-1][C_VD];
        end
    endgenerate

    logic [3*CW-1:0] src_data;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [AW-1:0] BAR_W = AW'(H_ACTIVE / 8);

    logic [2:0]    bar;
    logic [3*CW:0] pat_src;
    logic [3*CW:0] pat_tap;

    // Bar order white..black maps to RGB bits r=~b1, g=~b2, b=~b0 of the bar index
    assign bar     = 3'(h_addr / BAR_W);
    assign pat_src = {pattern_sel, {CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}};

    // Pattern and its select travel with the same latency as upstream data
    generate
        if (DATA_LAT == 0) begin : g_pat0
            assign pat_tap = pat_src;
        end else begin : g_patn
            logic [3*CW:0] pat_d [DATA_LAT];

            always_ff @(posedge pclk) begin
                if (reset) begin
                    for (int i = 0; i < DATA_LAT; i++) pat_d[i] <= '0;
                end else if (pix_ce) begin
                    pat_d[0] <= pat_src;
                    for (int i = 1; i < DATA_LAT; i++) pat_d[i] <= pat_d[i-1];
                end
            end

            assign pat_tap = pat_d[DATA_LAT-1];
        end
    endgenerate

    assign src_data = pat_tap[3*CW] ? pat_tap[3*CW-1:0] : vga_data;
`else
    assign src_data = vga_data;
`endif

    logic [3*CW-1:0] rgb;

    always_ff @(posedge pclk) begin
        if (reset) begin
            rgb <= '0;
        end else if (pix_ce) begin
            rgb <= req_tap ? src_data : '0;
        end
    end

    logic hs_q;
    logic vs_q;

    assign hs_q        = ctl_d[D-1][C_HS];
    assign vs_q        = ctl_d[D-1][C_VS];
    assign hsync       = (HS_POL != 0) ? hs_q : ~hs_q;
    assign vsync       = (VS_POL != 0) ? vs_q : ~vs_q;
    assign valid       = ctl_d[D-1][C_VD];
    assign line_start  = ctl_d[D-1][C_LS];
    assign frame_start = ctl_d[D-1][C_FS];
    assign vga_r       = rgb[3*CW-1:2*CW];
    assign vga_g       = rgb[2*CW-1:CW];
    assign vga_b       = rgb[CW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen using a reduced video mode.
// Drives reset/pix_ce, models a DATA_LAT-deep upstream source, checks every output each cycle.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int L  = 3;
    localparam int CW = 8;
    localparam int AW = 10;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_ce = 1'b0;
    logic [23:0]   vga_data;
    logic [AW-1:0] h_addr;
    logic [AW-1:0] v_addr;
    logic          addr_req;
    logic          hsync;
    logic          vsync;
    logic          valid;
    logic          frame_start;
    logic          line_start;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;
    logic          psel_m = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    logic          pattern_sel = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int e = 0;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .DATA_LAT(L), .CW(CW), .AW(AW)
    ) dut (
        .pclk(pclk),
        .reset(reset),
        .pix_ce(pix_ce),
        .vga_data(vga_data),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .h_addr(h_addr),
        .v_addr(v_addr),
        .addr_req(addr_req),
        .hsync(hsync),
        .vsync(vsync),
        .valid(valid),
        .frame_start(frame_start),
        .line_start(line_start),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b)
    );

    // Upstream source: returns {x, y, 5A} L enabled cycles after the address
    logic [7:0] hp [L];
    logic [7:0] vp [L];

    always @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                hp[i] <= '0;
                vp[i] <= '0;
            end
        end else if (pix_ce) begin
            hp[0] <= h_addr[7:0];
            vp[0] <= v_addr[7:0];
            for (int i = 1; i < L; i++) begin
                hp[i] <= hp[i-1];
                vp[i] <= vp[i-1];
            end
        end
    end

    assign vga_data = {hp[L-1], vp[L-1], 8'h5A};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int x);
        case (x / (HA / 8))
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_all();
        int h;
        int v;
        int k;
        logic req;
        logic [23:0] rgb;
        h = e % HT;
        v = (e / HT) % VT;
        req = (h < HA) && (v < VA);
        chk("addr_req", 32'(addr_req), 32'(req));
        chk("h_addr", 32'(h_addr), req ? h : 0);
        chk("v_addr", 32'(v_addr), req ? v : 0);
        if (e < L + 1) begin
            chk("hsync", 32'(hsync), 1);
            chk("vsync", 32'(vsync), 1);
            chk("valid", 32'(valid), 0);
            chk("frame_start", 32'(frame_start), 0);
            chk("line_start", 32'(line_start), 0);
            chk("rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
        end else begin
            k = e - L - 1;
            h = k % HT;
            v = (k / HT) % VT;
            req = (h < HA) && (v < VA);
            rgb = psel_m ? bar_rgb(h) : {h[7:0], v[7:0], 8'h5A};
            chk("hsync", 32'(hsync), (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
            chk("vsync", 32'(vsync), (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
            chk("valid", 32'(valid), 32'(req));
            chk("frame_start", 32'(frame_start), (h == 0 && v == 0) ? 1 : 0);
            chk("line_start", 32'(line_start), (h == 0 && v < VA) ? 1 : 0);
            chk("rgb", {8'h0, vga_r, vga_g, vga_b}, req ? {8'h0, rgb} : 0);
        end
    endtask

    task automatic step(input logic ce);
        pix_ce = ce;
        @(posedge pclk);
        if (reset) e = 0;
        else if (ce) e++;
        #1;
        check_all();
    endtask

    int fs_cnt;
    int ls_cnt;
    int vd_cnt;
    int hl_cnt;
    int vl_cnt;
    int first_fs;
    logic [31:0] snap;

    initial begin
        // Reset held three cycles with pix_ce high
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);

        // Two full frames, counting pulses and levels
        reset = 1'b0;
        fs_cnt = 0; ls_cnt = 0; vd_cnt = 0; hl_cnt = 0; vl_cnt = 0;
        first_fs = -1;
        for (int i = 1; i <= L + 2 * FT; i++) begin
            step(1'b1);
            if (frame_start && first_fs < 0) first_fs = i;
            if (i > L) begin
                fs_cnt += int'(frame_start);
                ls_cnt += int'(line_start);
                vd_cnt += int'(valid);
                hl_cnt += int'(!hsync);
                vl_cnt += int'(!vsync);
            end
        end
        chk("fs_first", first_fs, L + 1);
        chk("fs_count", fs_cnt, 2);
        chk("ls_count", ls_cnt, 2 * VA);
        chk("valid_count", vd_cnt, 2 * HA * VA);
        chk("hsync_low", hl_cnt, 2 * VT * HS);
        chk("vsync_low", vl_cnt, 2 * VS * HT);

        // pix_ce toggling: model advances only on enabled edges, held cycles frozen
        for (int i = 0; i < 4 * HT; i++) begin
            snap = {hsync, vsync, valid, frame_start, line_start, 3'b0, vga_r, vga_g, vga_b};
            step(i % 2 == 0);
            if (i % 2 == 1)
                chk("frozen", {hsync, vsync, valid, frame_start, line_start, 3'b0,
                               vga_r, vga_g, vga_b}, snap);
        end

        // Mid-frame reset at h=10, v=3
        for (int i = 0; i < FT && !((e % HT) == 10 && ((e / HT) % VT) == 3); i++)
            step(1'b1);
        chk("mid_pos", e % HT + 100 * ((e / HT) % VT), 310);
        reset = 1'b1;
        step(1'b1);
        chk("mid_rst_hsync", 32'(hsync), 1);
        chk("mid_rst_valid", 32'(valid), 0);
        reset = 1'b0;
        first_fs = -1;
        for (int i = 1; i <= 2 * HT; i++) begin
            step(1'b1);
            if (frame_start && first_fs < 0) first_fs = i;
        end
        chk("mid_fs_first", first_fs, L + 1);

`ifdef VGA_TEST_PATTERN_EN
        pattern_sel = 1'b1;
        psel_m = 1'b1;
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        for (int i = 1; i <= L + FT; i++) begin
            step(1'b1);
            if (e == L + 1)
                chk("bar_x0", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFFFF);
            if (e == L + 1 + HA / 8)
                chk("bar_x1", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFF00);
            if (e == L + HA)
                chk("bar_xlast", {8'h0, vga_r, vga_g, vga_b}, 32'h000000);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
